axi_read_arbiter: RTL and testbench
===================================

# axi_read_arbiter

Two-requester arbiter that shares the core's single AXI4 read channel between ICache and DCache line refills. Each refill is one 128-bit line, matching `AXI_DATA_WIDTH`, so every transaction is a single-beat burst. The block sits between the cache miss handlers and the core's top-level AXI master port. It uses round-robin priority and allows one outstanding transaction at a time.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `AXI_DATA_WIDTH`, 128, R data width; equals one cache line.
- `ID_WIDTH`, 4, arid/rid width.
- `ICACHE_ID`, 0, arid used for ICache requests.
- `DCACHE_ID`, 1, arid used for DCache requests.

Ports (`req`/`rsp` ports are duplicated with prefix `ic_` for ICache and `dc_` for DCache; one clock, reset asynchronous, active-low):
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous active-low reset.
- `{ic,dc}_req_valid` in 1: refill request.
- `{ic,dc}_req_ready` out 1: request accepted this cycle.
- `{ic,dc}_req_addr` in ADDR_WIDTH: line address.
- `{ic,dc}_req_size` in 3: arsize (AXI encoding).
- `{ic,dc}_rsp_valid` out 1: response data valid.
- `{ic,dc}_rsp_ready` in 1: requester accepts response.
- `{ic,dc}_rsp_data` out AXI_DATA_WIDTH: rdata.
- `{ic,dc}_rsp_error` out 1: rresp != OKAY, or rid mismatch.
- `araddr`/`arid`/`arlen`/`arsize`/`arburst`/`arvalid` out: AR channel.
- `arready` in 1: AR channel ready.
- `rid`/`rdata`/`rresp`/`rlast`/`rvalid` in: R channel.
- `rready` out 1: R channel ready.
- `protocol_err` out 1: sticky flag, set on an rid mismatch.
- `perf_ic_grants`, `perf_dc_grants`, `perf_wait_cycles` out 32 each: performance counters (see Configuration).

## Operation
- FSM states: IDLE, ADDR, DATA. Reset state is IDLE.
- **IDLE**
  - If any `req_valid` is high, grant one requester and assert its `req_ready`.
  - Latch `addr`, `size`, `owner` and go to ADDR.
  - When both requesters are valid, priority pointer `prio` decides; `prio`=0 favours ICache. Reset value of `prio` is 0.
- **ADDR**
  - `arvalid`=1 with the latched fields; `arid` is the owner's ID.
  - `arlen`=0 and `arburst`=2'b01 are constant.
  - The AR fields stay stable until `arready`. On `arvalid & arready`, go to DATA.
- **DATA**
  - `rready` = the owner's `rsp_ready`.
  - The owner's `rsp_valid` = `rvalid`; `rsp_data` = `rdata`.
  - `rsp_error` = (`rresp != 2'b00`) | (`rid != arid_latched`).
  - The non-owner's `rsp_valid` is 0.
  - On `rvalid & rready & rlast`: go to IDLE and set `prio` to favour the non-owner.
  - `rvalid & rready` without `rlast` is a protocol violation: set `protocol_err` and remain in DATA.
- In IDLE and ADDR, `rready`=0, so stray R beats are not consumed.
- On an rid mismatch the beat is still consumed and delivered with `rsp_error`=1, and `protocol_err` is set. `protocol_err` clears only on reset.
- Requests are never dropped. A requester that is not granted stays pending with `req_valid` held high.

## Timing
- Reset values:
  - state = IDLE.
  - `arvalid`, `rready`, `req_ready`, `rsp_valid`, `rsp_error`, `protocol_err` = 0.
  - `araddr`, `arid`, `arsize` = 0.
  - Perf counters = 0.
- `req_ready` is combinational from `req_valid`, `prio` and state (IDLE only).
- `arvalid` rises the cycle after acceptance, so the request-to-AR latency is 1 cycle.
- The response path is combinational: R channel to `rsp_*` in 0 cycles.
- The next request can be accepted in the cycle after the final R handshake. Minimum per-transaction period is 3 cycles with zero-wait slave.
- Only one transaction is in flight; a new AR is never issued before the last R beat.
- A new request arriving during ADDR or DATA waits; its `req_ready`=0.
- An asynchronous reset mid-transaction returns the FSM to IDLE immediately and drops the AR/R handshake.

## Configuration
- Macro `AXI_ARB_PERF_EN`.
- **Defined:**
  - `perf_ic_grants` and `perf_dc_grants` increment on each grant to the respective requester.
  - `perf_wait_cycles` increments every cycle in which a `req_valid` is high and that requester's `req_ready` is low.
  - All three are 32-bit, wrap modulo 2^32, and are reset to 0.
- **Undefined:** the three outputs are tied to 0 and no counter flops are built.

## Test plan
- ICache alone, `addr`=0x1C00_0000, zero-wait slave:
  - -> `ic_req_ready` in cycle 0.
  - -> `arvalid` in cycle 1 with `arid`=0, `arlen`=0, `arburst`=01.
  - -> `ic_rsp_valid` with data; back in IDLE in cycle 3.
- Both requesters valid from reset:
  - -> ICache granted first, DCache second.
  - -> Repeated back-to-back requests alternate IC, DC, IC, DC.
- `arready` held low 5 cycles:
  - -> `araddr`/`arid`/`arsize`/`arvalid` stay stable.
  - -> No second `req_ready` is issued.
- DCache owner with `dc_rsp_ready`=0 for 3 cycles while `rvalid`=1:
  - -> `rready`=0 during those cycles.
  - -> Data handed over on the 4th cycle.
- Slave returns `rresp`=2'b10, then later `rid`=5 on an ICache transaction:
  - -> `ic_rsp_error`=1 for each.
  - -> `protocol_err` set after the rid case and held until `aresetn` low.
- `aresetn` pulsed low during DATA:
  - -> State returns to IDLE and all outputs go to their reset values.
  - -> With `AXI_ARB_PERF_EN` defined, counters read 0 afterward.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// -----------------------------------------------------------------------------
// axi_read_arbiter
//
// Shares the core's single AXI4 read channel between ICache and DCache line
// refills. Each refill is one AXI_DATA_WIDTH-bit line moved as a single-beat
// burst. Round-robin priority, one outstanding transaction at a time.
//
// Ports
//   aclk, aresetn                 clock, asynchronous active-low reset
//   {ic,dc}_req_valid/ready       refill request handshake (ready only in IDLE)
//   {ic,dc}_req_addr/size         line address and AXI arsize encoding
//   {ic,dc}_rsp_valid/ready       response handshake, combinational from R
//   {ic,dc}_rsp_data/error        rdata and (rresp != OKAY | rid mismatch)
//   ar*                           AXI AR channel (arlen = 0, arburst = INCR)
//   r*                            AXI R channel
//   protocol_err                  sticky: rid mismatch or beat without rlast
//   perf_*                        grant / wait-cycle counters
//
// Optional feature: define AXI_ARB_PERF_EN to build the performance counters.
// Without it the perf_* outputs are tied to 0 and no counter flops exist.
// -----------------------------------------------------------------------------
module axi_read_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int ID_WIDTH       = 4,
  parameter int ICACHE_ID      = 0,
  parameter int DCACHE_ID      = 1
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  // ICache requester
  input  logic                      ic_req_valid,
  output logic                      ic_req_ready,
  input  logic [ADDR_WIDTH-1:0]     ic_req_addr,
  input  logic [2:0]                ic_req_size,
  output logic                      ic_rsp_valid,
  input  logic                      ic_rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0] ic_rsp_data,
  output logic                      ic_rsp_error,
  // DCache requester
  input  logic                      dc_req_valid,
  output logic                      dc_req_ready,
  input  logic [ADDR_WIDTH-1:0]     dc_req_addr,
  input  logic [2:0]                dc_req_size,
  output logic                      dc_rsp_valid,
  input  logic                      dc_rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0] dc_rsp_data,
  output logic                      dc_rsp_error,
  // AXI AR channel
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic [ID_WIDTH-1:0]       arid,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic                      arvalid,
  input  logic                      arready,
  // AXI R channel
  input  logic [ID_WIDTH-1:0]       rid,
  input  logic [AXI_DATA_WIDTH-1:0] rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready,
  // Status
  output logic                      protocol_err,
  output logic [31:0]               perf_ic_grants,
  output logic [31:0]               perf_dc_grants,
  output logic [31:0]               perf_wait_cycles
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                  state_q, state_d;
  logic                    prio_q, prio_d;     // 1 = favour DCache on a tie
  logic                    owner_q, owner_d;   // 1 = DCache owns the channel
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [ID_WIDTH-1:0]     arid_q, arid_d;
  logic [2:0]              arsize_q, arsize_d;
  logic                    protocol_err_q, protocol_err_d;

  logic                    in_data;
  logic                    r_hs;
  logic                    rid_bad;
  logic                    beat_err;

  // ---------------------------------------------------------------------------
  // Next-state / request-side outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    prio_d         = prio_q;
    owner_d        = owner_q;
    araddr_d       = araddr_q;
    arid_d         = arid_q;
    arsize_d       = arsize_q;
    protocol_err_d = protocol_err_q;
    ic_req_ready   = 1'b0;
    dc_req_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        // A lone requester always wins; on a tie prio picks the side.
        ic_req_ready = ic_req_valid & (~dc_req_valid | ~prio_q);
        dc_req_ready = dc_req_valid & (~ic_req_valid |  prio_q);
        if (ic_req_ready) begin
          owner_d  = 1'b0;
          araddr_d = ic_req_addr;
          arsize_d = ic_req_size;
          arid_d   = ID_WIDTH'(ICACHE_ID);
          state_d  = ADDR;
        end else if (dc_req_ready) begin
          owner_d  = 1'b1;
          araddr_d = dc_req_addr;
          arsize_d = dc_req_size;
          arid_d   = ID_WIDTH'(DCACHE_ID);
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (arready) state_d = DATA;
      end
      DATA: begin
        if (r_hs) begin
          if (rid_bad) protocol_err_d = 1'b1;
          if (rlast) begin
            state_d = IDLE;
            prio_d  = ~owner_q;
          end else begin
            // Every refill is a single beat, so a beat without rlast is illegal;
            // stay in DATA and wait for the terminating beat.
            protocol_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= IDLE;
      prio_q         <= 1'b0;
      owner_q        <= 1'b0;
      araddr_q       <= '0;
      arid_q         <= '0;
      arsize_q       <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      prio_q         <= prio_d;
      owner_q        <= owner_d;
      araddr_q       <= araddr_d;
      arid_q         <= arid_d;
      arsize_q       <= arsize_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // AXI and response-side outputs
  // ---------------------------------------------------------------------------
  assign arvalid      = (state_q == ADDR);
  assign araddr       = araddr_q;
  assign arid         = arid_q;
  assign arsize       = arsize_q;
  assign arlen        = 8'd0;
  assign arburst      = 2'b01;

  assign in_data      = (state_q == DATA);
  // R beats outside DATA are left on the bus untouched.
  assign rready       = in_data & (owner_q ? dc_rsp_ready : ic_rsp_ready);
  assign r_hs         = rvalid & rready;
  assign rid_bad      = (rid != arid_q);
  assign beat_err     = (rresp != 2'b00) | rid_bad;

  assign ic_rsp_valid = in_data & ~owner_q & rvalid;
  assign dc_rsp_valid = in_data &  owner_q & rvalid;
  assign ic_rsp_error = ic_rsp_valid & beat_err;
  assign dc_rsp_error = dc_rsp_valid & beat_err;
  assign ic_rsp_data  = rdata;
  assign dc_rsp_data  = rdata;

  assign protocol_err = protocol_err_q;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef AXI_ARB_PERF_EN
  logic [31:0] perf_ic_q, perf_ic_d;
  logic [31:0] perf_dc_q, perf_dc_d;
  logic [31:0] perf_wait_q, perf_wait_d;

  always_comb begin
    perf_ic_d   = perf_ic_q   + {31'd0, ic_req_ready};
    perf_dc_d   = perf_dc_q   + {31'd0, dc_req_ready};
    // One count per cycle in which at least one requester is stalled.
    perf_wait_d = perf_wait_q + {31'd0, (ic_req_valid & ~ic_req_ready) |
                                        (dc_req_valid & ~dc_req_ready)};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      perf_ic_q   <= '0;
      perf_dc_q   <= '0;
      perf_wait_q <= '0;
    end else begin
      perf_ic_q   <= perf_ic_d;
      perf_dc_q   <= perf_dc_d;
      perf_wait_q <= perf_wait_d;
    end
  end

  assign perf_ic_grants   = perf_ic_q;
  assign perf_dc_grants   = perf_dc_q;
  assign perf_wait_cycles = perf_wait_q;
`else
  assign perf_ic_grants   = 32'd0;
  assign perf_dc_grants   = 32'd0;
  assign perf_wait_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_axi_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_read_arbiter
//
// Randomized bench for axi_read_arbiter. Two requester agents and an AXI read
// slave are driven from $urandom; a transaction-level reference model (who is
// waiting, who was served last, which phase the single outstanding refill is
// in) predicts every DUT output each cycle. Directed sequences cover the
// reset-state, latency, tie-break, AR back-pressure, R back-pressure, error
// and mid-transaction reset cases. Define AXI_ARB_PERF_EN to also check the
// performance counters against the model.
// -----------------------------------------------------------------------------
module tb_axi_read_arbiter;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int IW = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          ic_req_valid = 0, dc_req_valid = 0;
  logic          ic_req_ready, dc_req_ready;
  logic [AW-1:0] ic_req_addr = '0, dc_req_addr = '0;
  logic [2:0]    ic_req_size = '0, dc_req_size = '0;
  logic          ic_rsp_valid, dc_rsp_valid;
  logic          ic_rsp_ready = 0, dc_rsp_ready = 0;
  logic [DW-1:0] ic_rsp_data, dc_rsp_data;
  logic          ic_rsp_error, dc_rsp_error;
  logic [AW-1:0] araddr;
  logic [IW-1:0] arid;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready = 0;
  logic [IW-1:0] rid = '0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = '0;
  logic          rlast = 0, rvalid = 0;
  logic          rready;
  logic          protocol_err;
  logic [31:0]   perf_ic_grants, perf_dc_grants, perf_wait_cycles;

  always #5 aclk = ~aclk;

  axi_read_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready),
    .ic_req_addr(ic_req_addr), .ic_req_size(ic_req_size),
    .ic_rsp_valid(ic_rsp_valid), .ic_rsp_ready(ic_rsp_ready),
    .ic_rsp_data(ic_rsp_data), .ic_rsp_error(ic_rsp_error),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
    .dc_req_addr(dc_req_addr), .dc_req_size(dc_req_size),
    .dc_rsp_valid(dc_rsp_valid), .dc_rsp_ready(dc_rsp_ready),
    .dc_rsp_data(dc_rsp_data), .dc_rsp_error(dc_rsp_error),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .protocol_err(protocol_err),
    .perf_ic_grants(perf_ic_grants), .perf_dc_grants(perf_dc_grants),
    .perf_wait_cycles(perf_wait_cycles)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stimulus knobs (percentages)
  int ic_pct, dc_pct, ar_pct, r_pct, rr_pct, resp_err_pct, rid_err_pct, nolast_pct, stray_pct;

  // Requester agents
  bit          ic_pend, dc_pend;
  logic [31:0] ic_a, dc_a;
  logic [2:0]  ic_s, dc_s;
  bit          rv_hold;

  // Reference model: phase 0 = free, 1 = address pending, 2 = awaiting data
  int          ph;
  bit          own;          // 1 = DCache
  logic [31:0] m_addr;
  logic [2:0]  m_size;
  bit          fav_dc;       // last served was ICache
  bit          m_perr;
  logic [31:0] m_icg, m_dcg, m_wait;
  int          txn;

  function automatic logic [IW-1:0] own_id();
    return own ? IW'(1) : IW'(0);
  endfunction

  task automatic model_reset();
    ph = 0; own = 0; fav_dc = 0; m_perr = 0;
    m_icg = 0; m_dcg = 0; m_wait = 0;
    ic_pend = 0; dc_pend = 0; rv_hold = 0;
  endtask

  task automatic set_knobs(input int icp, input int dcp, input int ar, input int r, input int rr,
                           input int re, input int ie, input int nl, input int st);
    ic_pct = icp; dc_pct = dcp; ar_pct = ar; r_pct = r; rr_pct = rr;
    resp_err_pct = re; rid_err_pct = ie; nolast_pct = nl; stray_pct = st;
  endtask

  function automatic bit roll(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic check_reset_outputs();
    check("rst_ic_req_ready", ic_req_ready, 0);
    check("rst_dc_req_ready", dc_req_ready, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_ic_rsp_valid", ic_rsp_valid, 0);
    check("rst_dc_rsp_valid", dc_rsp_valid, 0);
    check("rst_ic_rsp_error", ic_rsp_error, 0);
    check("rst_dc_rsp_error", dc_rsp_error, 0);
    check("rst_protocol_err", protocol_err, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arid", arid, 0);
    check("rst_arsize", arsize, 0);
    check("rst_perf_ic", perf_ic_grants, 0);
    check("rst_perf_dc", perf_dc_grants, 0);
    check("rst_perf_wait", perf_wait_cycles, 0);
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step();
    bit exp_icr, exp_dcr, exp_rr, hs;
    @(posedge aclk);
    #1;
    if (!ic_pend && roll(ic_pct)) begin ic_pend = 1; ic_a = $urandom; ic_s = 3'($urandom_range(7)); end
    if (!dc_pend && roll(dc_pct)) begin dc_pend = 1; dc_a = $urandom; dc_s = 3'($urandom_range(7)); end
    ic_req_valid = ic_pend; ic_req_addr = ic_a; ic_req_size = ic_s;
    dc_req_valid = dc_pend; dc_req_addr = dc_a; dc_req_size = dc_s;
    ic_rsp_ready = roll(rr_pct);
    dc_rsp_ready = roll(rr_pct);
    arready      = roll(ar_pct);
    if (ph == 2) begin
      if (!rv_hold) begin
        if (roll(r_pct)) begin
          rv_hold = 1;
          rvalid  = 1;
          rdata   = {$urandom, $urandom, $urandom, $urandom};
          rresp   = roll(resp_err_pct) ? 2'($urandom_range(1, 3)) : 2'b00;
          rid     = roll(rid_err_pct) ? IW'(5) : own_id();
          rlast   = !roll(nolast_pct);
        end else begin
          rvalid = 0;
        end
      end
    end else begin
      rv_hold = 0;
      rvalid  = roll(stray_pct);
      rdata   = {$urandom, $urandom, $urandom, $urandom};
      rid     = IW'($urandom_range(15));
      rresp   = 2'($urandom_range(3));
      rlast   = 1;
    end
    #3;
    exp_icr = (ph == 0) && ic_pend && (!dc_pend || !fav_dc);
    exp_dcr = (ph == 0) && dc_pend && (!ic_pend || fav_dc);
    exp_rr  = (ph == 2) && (own ? dc_rsp_ready : ic_rsp_ready);
    check("ic_req_ready", ic_req_ready, exp_icr);
    check("dc_req_ready", dc_req_ready, exp_dcr);
    check("arvalid", arvalid, ph == 1);
    if (ph == 1) begin
      check("araddr", araddr, m_addr);
      check("arid", arid, own_id());
      check("arsize", arsize, m_size);
      check("arlen", arlen, 0);
      check("arburst", arburst, 2'b01);
    end
    check("rready", rready, exp_rr);
    check("ic_rsp_valid", ic_rsp_valid, (ph == 2) && !own && rvalid);
    check("dc_rsp_valid", dc_rsp_valid, (ph == 2) && own && rvalid);
    if (ph == 2 && rvalid) begin
      if (own) begin
        check("dc_rsp_data", dc_rsp_data, rdata);
        check("dc_rsp_error", dc_rsp_error, (rresp != 0) || (rid != own_id()));
      end else begin
        check("ic_rsp_data", ic_rsp_data, rdata);
        check("ic_rsp_error", ic_rsp_error, (rresp != 0) || (rid != own_id()));
      end
    end
    check("protocol_err", protocol_err, m_perr);
`ifdef AXI_ARB_PERF_EN
    check("perf_ic_grants", perf_ic_grants, m_icg);
    check("perf_dc_grants", perf_dc_grants, m_dcg);
    check("perf_wait_cycles", perf_wait_cycles, m_wait);
`else
    check("perf_tied_zero", perf_ic_grants | perf_dc_grants | perf_wait_cycles, 0);
`endif
    // Advance the model with this cycle's handshakes.
    if ((ic_pend && !exp_icr) || (dc_pend && !exp_dcr)) m_wait++;
    case (ph)
      0: begin
        if (exp_icr) begin
          own = 0; m_addr = ic_a; m_size = ic_s; ic_pend = 0; m_icg++; ph = 1;
        end else if (exp_dcr) begin
          own = 1; m_addr = dc_a; m_size = dc_s; dc_pend = 0; m_dcg++; ph = 1;
        end
      end
      1: if (arready) ph = 2;
      default: begin
        hs = rvalid && exp_rr;
        if (hs) begin
          rv_hold = 0;
          if (rid != own_id()) m_perr = 1;
          if (rlast) begin
            txn++;
            $display("txn %0d owner=%s addr=%08h size=%0d rresp=%0d rid=%0d data=%032h",
                     txn, own ? "DC" : "IC", m_addr, m_size, rresp, rid, rdata);
            ph = 0;
            fav_dc = !own;
          end else begin
            m_perr = 1;
          end
        end
      end
    endcase
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Assert reset asynchronously in mid-cycle, check reset values, release.
  task automatic async_reset();
    #2;
    aresetn = 0;
    ic_req_valid = 0; dc_req_valid = 0; rvalid = 0; arready = 0;
    ic_rsp_ready = 0; dc_rsp_ready = 0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge aclk);
    #1;
    check_reset_outputs();
    @(negedge aclk);
    aresetn = 1;
    model_reset();
  endtask

  initial begin
    bit reached;
    txn = 0;
    model_reset();
    set_knobs(0, 0, 100, 100, 100, 0, 0, 0, 0);
    #12;
    check_reset_outputs();
    @(negedge aclk);
    aresetn = 1;

    // ICache alone at 0x1C00_0000, zero-wait slave
    ic_pend = 1; ic_a = 32'h1C00_0000; ic_s = 3'd4;
    run(4);

    // Both requesters valid back-to-back: IC, DC, IC, DC ...
    set_knobs(100, 100, 100, 100, 100, 0, 0, 0, 0);
    ic_pend = 1; ic_a = $urandom; ic_s = 3'd4;
    dc_pend = 1; dc_a = $urandom; dc_s = 3'd4;
    run(12);

    // arready held low: AR fields stable, no further grant
    set_knobs(100, 100, 0, 100, 100, 0, 0, 0, 0);
    run(7);
    set_knobs(0, 0, 100, 100, 100, 0, 0, 0, 0);
    run(6);

    // DCache owner with rsp_ready low for several cycles while rvalid is high
    set_knobs(0, 0, 100, 100, 0, 0, 0, 0, 0);
    dc_pend = 1; dc_a = $urandom; dc_s = 3'd4;
    run(5);
    set_knobs(0, 0, 100, 100, 100, 0, 0, 0, 0);
    run(3);

    // Randomized traffic, well-formed slave with stray R beats outside DATA
    set_knobs(40, 40, 60, 60, 70, 0, 0, 0, 20);
    run(3000);
    set_knobs(0, 0, 100, 100, 100, 0, 0, 0, 0);
    run(8);

    // rresp error on ICache, then rid mismatch on ICache
    set_knobs(0, 0, 100, 100, 100, 100, 0, 0, 0);
    ic_pend = 1; ic_a = $urandom; ic_s = 3'd4;
    run(4);
    set_knobs(0, 0, 100, 100, 100, 0, 100, 0, 0);
    ic_pend = 1; ic_a = $urandom; ic_s = 3'd4;
    run(4);
    set_knobs(40, 40, 60, 60, 70, 0, 0, 0, 10);
    run(50);

    // Reset pulsed while a transaction is waiting for data
    set_knobs(100, 100, 100, 0, 100, 0, 0, 0, 0);
    reached = 0;
    for (int i = 0; i < 100 && !reached; i++) begin
      step();
      if (ph == 2) reached = 1;
    end
    check("reach_data_phase", reached, 1);
    @(posedge aclk);
    async_reset();

    // Randomized traffic including error beats and missing rlast
    set_knobs(40, 40, 60, 60, 70, 10, 10, 10, 20);
    run(2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
